// File: rtl/uart_rx_deserializer_if.sv
// Bundle for the UART receiver: the serial line and per-frame parity
// configuration in, the deserialized word and its status flags out.
interface uart_rx_deserializer_if #(
   parameter int DATA_BITS = 8
);
   logic                 s_data_in;
   logic                 parity_en;
   logic                 parity_type;
   logic [DATA_BITS-1:0] p_data_out;
   logic                 data_valid;
   logic                 parity_error;
   logic                 framing_error;

   // Side that drives the line and consumes received words.
   modport master (
      output s_data_in, parity_en, parity_type,
      input  p_data_out, data_valid, parity_error, framing_error
   );

   // Receiver side.
   modport slave (
      input  s_data_in, parity_en, parity_type,
      output p_data_out, data_valid, parity_error, framing_error
   );
endinterface

// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receiver. The asynchronous line is synchronized,
// a falling edge is qualified at the middle of the start bit, and each
// following bit is sampled once per bit period at its midpoint. Word and
// error flags are registered together with a one-cycle data_valid pulse.
module uart_rx_deserializer #(
   parameter int OVERSAMPLE = 8,
   parameter int DATA_BITS  = 8
) (
   input  logic                  baud_rate_rx,
   input  logic                  rst,
   uart_rx_deserializer_if.slave bus
);
   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state, state_next;
   logic [CNT_W-1:0]     cnt, cnt_next;
   logic [IDX_W-1:0]     idx, idx_next;
   logic                 sync_meta, sync_rx;
   logic                 par_en_q, par_type_q, par_flag;
   logic [DATA_BITS-1:0] shift_q;
   logic                 start_frame, take_data, take_parity, take_stop;
   logic                 bit_tick;
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q, perr_q, ferr_q;

   // Two-flop synchronizer; resets to the idle-high line level.
   // NOTE: clocked state uses non-blocking (<=) so every flop samples the
   // pre-edge values of the others, regardless of statement order.
   always_ff @(posedge baud_rate_rx) begin
      if (rst) begin
         sync_meta <= 1'b1;
         sync_rx   <= 1'b1;
      end else begin
         sync_meta <= bus.s_data_in;
         sync_rx   <= sync_meta;
      end
   end

   // FSM state, oversample counter and bit index registers.
   always_ff @(posedge baud_rate_rx) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         idx   <= idx_next;
      end
   end

   assign bit_tick = (cnt == BIT_LAST);

   // Next-state logic and the per-bit sampling strobes.
   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt + CNT_W'(1);
      idx_next    = idx;
      start_frame = 1'b0;
      take_data   = 1'b0;
      take_parity = 1'b0;
      take_stop   = 1'b0;
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (!sync_rx) begin
               state_next  = START;
               start_frame = 1'b1;
            end
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_next = '0;
               if (sync_rx) begin
                  state_next = IDLE;       // too short: treat as a glitch
               end else begin
                  state_next = DATA;
                  idx_next   = '0;
               end
            end
         end
         DATA: begin
            if (bit_tick) begin
               cnt_next  = '0;
               take_data = 1'b1;
               if (idx == IDX_LAST) begin
                  state_next = par_en_q ? PARITY : STOP;
               end else begin
                  idx_next = idx + IDX_W'(1);
               end
            end
         end
         PARITY: begin
            if (bit_tick) begin
               cnt_next    = '0;
               take_parity = 1'b1;
               state_next  = STOP;
            end
         end
         STOP: begin
            if (bit_tick) begin
               cnt_next   = '0;
               take_stop  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Frame-scoped config capture, LSB-first shift register and parity check.
   always_ff @(posedge baud_rate_rx) begin
      if (rst) begin
         par_en_q   <= 1'b0;
         par_type_q <= 1'b0;
         par_flag   <= 1'b0;
         shift_q    <= '0;
      end else begin
         if (start_frame) begin
            par_en_q   <= bus.parity_en;
            par_type_q <= bus.parity_type;
            par_flag   <= 1'b0;
         end
         if (take_data) begin
            shift_q <= {sync_rx, shift_q[DATA_BITS-1:1]};
         end
         if (take_parity) begin
            par_flag <= (sync_rx != (^shift_q ^ par_type_q));
         end
      end
   end

   // Result registers: updated only on the stop sample, held otherwise.
   always_ff @(posedge baud_rate_rx) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         valid_q <= take_stop;
         if (take_stop) begin
            data_q <= shift_q;
            perr_q <= par_flag;
            ferr_q <= ~sync_rx;
         end
      end
   end

   assign bus.p_data_out    = data_q;
   assign bus.data_valid    = valid_q;
   assign bus.parity_error  = perr_q;
   assign bus.framing_error = ferr_q;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed frames for the
// main behaviours plus randomized frames scored against a word-level model.
module tb_uart_rx_deserializer;
   localparam int OS = 8;
   localparam int DB = 8;

   typedef struct packed {
      logic [DB-1:0] data;
      logic          perr;
      logic          ferr;
   } frame_t;

   logic   baud_rate_rx = 1'b0;
   logic   rst;
   int     vectors     = 0;
   int     miscompares = 0;
   frame_t got_q[$];
   frame_t exp_q[$];
   frame_t last_exp;
   frame_t got_f, exp_f;

   uart_rx_deserializer_if #(.DATA_BITS(DB)) bus ();

   uart_rx_deserializer #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
      .baud_rate_rx (baud_rate_rx),
      .rst          (rst),
      .bus          (bus)
   );

   always #5 baud_rate_rx = ~baud_rate_rx;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Capture every completed frame, sampled away from the active edge.
   always @(negedge baud_rate_rx) begin
      if (bus.data_valid === 1'b1)
         got_q.push_back({bus.p_data_out, bus.parity_error, bus.framing_error});
   end

   // Word-level reference: parity from the count of ones, framing from stop.
   function automatic frame_t model(input logic [DB-1:0] d, input logic pen,
                                    input logic ptype, input logic pbit,
                                    input logic stop);
      frame_t f;
      int     ones;
      logic   want;
      ones   = $countones(d);
      want   = ptype ? logic'((ones + 1) % 2) : logic'(ones % 2);
      f.data = d;
      f.perr = pen && (pbit != want);
      f.ferr = (stop == 1'b0);
      return f;
   endfunction

   task automatic drive_bit(input logic b);
      bus.s_data_in = b;
      repeat (OS) @(negedge baud_rate_rx);
   endtask

   // Sends one frame; optionally flips the parity config mid-frame.
   task automatic send_frame(input logic [DB-1:0] d, input logic pen,
                             input logic ptype, input logic pbit,
                             input logic stop, input int gap,
                             input bit scramble);
      bus.parity_en   = pen;
      bus.parity_type = ptype;
      drive_bit(1'b0);
      for (int i = 0; i < DB; i++) begin
         if (scramble && i == 3) begin
            bus.parity_en   = ~pen;
            bus.parity_type = ~ptype;
         end
         drive_bit(d[i]);
      end
      if (pen) drive_bit(pbit);
      drive_bit(stop);
      bus.s_data_in = 1'b1;
      repeat (gap * OS) @(negedge baud_rate_rx);
      exp_q.push_back(model(d, pen, ptype, pbit, stop));
      last_exp = model(d, pen, ptype, pbit, stop);
   endtask

   task automatic test_reset;
      rst             = 1'b1;
      bus.s_data_in   = 1'b1;
      bus.parity_en   = 1'b0;
      bus.parity_type = 1'b0;
      repeat (4) @(negedge baud_rate_rx);
      vectors++;
      if (bus.data_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_valid: got %b want 0", bus.data_valid);
      end
      vectors++;
      if (bus.p_data_out !== '0) begin
         miscompares++;
         $display("FAIL reset_data: got %h want 00", bus.p_data_out);
      end
      vectors++;
      if (bus.parity_error !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_perr: got %b want 0", bus.parity_error);
      end
      vectors++;
      if (bus.framing_error !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ferr: got %b want 0", bus.framing_error);
      end
      rst = 1'b0;
      repeat (2 * OS) @(negedge baud_rate_rx);
      last_exp = '0;
   endtask

   task automatic test_no_parity;
      send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
      repeat (2 * OS) @(negedge baud_rate_rx);
      vectors++;
      if (got_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL no_parity_count: got %0d want %0d", got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         got_f = got_q.pop_front();
         exp_f = exp_q.pop_front();
         vectors++;
         if (got_f !== exp_f) begin
            miscompares++;
            $display("FAIL no_parity_frame: got %h/%b/%b want %h/%b/%b",
                     got_f.data, got_f.perr, got_f.ferr, exp_f.data, exp_f.perr, exp_f.ferr);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_parity;
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0);  // even, correct
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0);  // even, wrong
      send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 2, 1'b0);  // odd, correct
      send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b0);  // low stop bit
      repeat (2 * OS) @(negedge baud_rate_rx);
      vectors++;
      if (got_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL parity_count: got %0d want %0d", got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         got_f = got_q.pop_front();
         exp_f = exp_q.pop_front();
         vectors++;
         if (got_f !== exp_f) begin
            miscompares++;
            $display("FAIL parity_frame: got %h/%b/%b want %h/%b/%b",
                     got_f.data, got_f.perr, got_f.ferr, exp_f.data, exp_f.perr, exp_f.ferr);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_glitch;
      bus.s_data_in = 1'b0;
      repeat (2) @(negedge baud_rate_rx);
      bus.s_data_in = 1'b1;
      repeat (4 * OS) @(negedge baud_rate_rx);
      vectors++;
      if (got_q.size() !== 0) begin
         miscompares++;
         $display("FAIL glitch_valid: got %0d pulses want 0", got_q.size());
      end
      vectors++;
      if ({bus.p_data_out, bus.parity_error, bus.framing_error} !== last_exp) begin
         miscompares++;
         $display("FAIL glitch_hold: got %h/%b/%b want %h/%b/%b", bus.p_data_out,
                  bus.parity_error, bus.framing_error, last_exp.data, last_exp.perr, last_exp.ferr);
      end
      got_q.delete();
   endtask

   task automatic test_back_to_back;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
      send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
      repeat (2 * OS) @(negedge baud_rate_rx);
      vectors++;
      if (got_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         got_f = got_q.pop_front();
         exp_f = exp_q.pop_front();
         vectors++;
         if (got_f !== exp_f) begin
            miscompares++;
            $display("FAIL b2b_frame: got %h/%b/%b want %h/%b/%b",
                     got_f.data, got_f.perr, got_f.ferr, exp_f.data, exp_f.perr, exp_f.ferr);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset_mid_frame;
      logic [DB-1:0] d;
      d = 8'h9A;
      bus.parity_en = 1'b0;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      bus.s_data_in = d[4];
      repeat (3) @(negedge baud_rate_rx);
      rst = 1'b1;
      repeat (2) @(negedge baud_rate_rx);
      rst = 1'b0;
      bus.s_data_in = 1'b1;
      repeat (8 * OS) @(negedge baud_rate_rx);
      vectors++;
      if (got_q.size() !== 0) begin
         miscompares++;
         $display("FAIL abort_valid: got %0d pulses want 0", got_q.size());
      end
      vectors++;
      if ({bus.p_data_out, bus.parity_error, bus.framing_error} !== '0) begin
         miscompares++;
         $display("FAIL abort_outputs: got %h/%b/%b want 00/0/0",
                  bus.p_data_out, bus.parity_error, bus.framing_error);
      end
      got_q.delete();
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
      repeat (2 * OS) @(negedge baud_rate_rx);
      vectors++;
      if (got_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL restart_count: got %0d want %0d", got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         got_f = got_q.pop_front();
         exp_f = exp_q.pop_front();
         vectors++;
         if (got_f !== exp_f) begin
            miscompares++;
            $display("FAIL restart_frame: got %h/%b/%b want %h/%b/%b",
                     got_f.data, got_f.perr, got_f.ferr, exp_f.data, exp_f.perr, exp_f.ferr);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_random;
      logic [DB-1:0] d;
      logic          pen, ptype, pbit, stop;
      int            gap;
      for (int n = 0; n < 24; n++) begin
         d     = DB'($urandom);
         pen   = logic'($urandom_range(0, 1));
         ptype = logic'($urandom_range(0, 1));
         pbit  = logic'($urandom_range(0, 1));
         stop  = ($urandom_range(0, 3) != 0);
         gap   = stop ? int'($urandom_range(0, 2)) : 2;
         send_frame(d, pen, ptype, pbit, stop, gap, bit'($urandom_range(0, 1)));
      end
      repeat (2 * OS) @(negedge baud_rate_rx);
      vectors++;
      if (got_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL random_count: got %0d want %0d", got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         got_f = got_q.pop_front();
         exp_f = exp_q.pop_front();
         vectors++;
         if (got_f !== exp_f) begin
            miscompares++;
            $display("FAIL random_frame: got %h/%b/%b want %h/%b/%b",
                     got_f.data, got_f.perr, got_f.ferr, exp_f.data, exp_f.perr, exp_f.ferr);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_no_parity();
      test_parity();
      test_glitch();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/uart_rx_deserializer.md
UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 Parameter OVERSAMPLE, default 8, SHALL be the number of baud_rate_rx cycles per serial bit period; legal values are even integers from 4 to 16.
REQ-002 Parameter DATA_BITS, default 8, SHALL be the number of data bits per frame.
REQ-003 baud_rate_rx  input  1  SHALL be the receive sampling clock running at OVERSAMPLE x baud rate, the only clock, all logic on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 s_data_in  input  1  SHALL be the asynchronous serial line, idle high.
REQ-006 parity_en  input  1  SHALL select whether a parity bit follows the data bits (1 = present).
REQ-007 parity_type  input  1  SHALL select parity sense: 0 = even, 1 = odd.
REQ-008 p_data_out  output  DATA_BITS  SHALL carry the last received data word.
REQ-009 data_valid  output  1  SHALL be a one-cycle pulse marking a completed frame.
REQ-010 parity_error  output  1  SHALL flag a parity mismatch in the frame reported by the last data_valid.
REQ-011 framing_error  output  1  SHALL flag a low stop bit in the frame reported by the last data_valid.

Function
REQ-012 s_data_in SHALL pass through a two-flop synchronizer reset to 1; all FSM decisions use the synchronized bit (2-cycle input latency).
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; a cycle counter 0..OVERSAMPLE-1 and a bit index 0..DATA_BITS-1 time each bit.
REQ-014 IDLE: synchronized line low -> START with counter cleared; parity_en and parity_type SHALL be latched in this same cycle and held for the frame.
REQ-015 START: at counter = OVERSAMPLE/2-1, line high -> IDLE (glitch rejected, no outputs change); line low -> DATA with counter and bit index cleared.
REQ-016 DATA/PARITY/STOP: each bit SHALL be sampled when counter = OVERSAMPLE-1, i.e. at the bit midpoint, after which counter wraps to 0.
REQ-017 Data SHALL be received LSB first: each sample enters bit DATA_BITS-1 of a shift register that shifts right; after DATA_BITS samples -> PARITY if latched parity_en = 1, else STOP.
REQ-018 PARITY: expected bit = XOR of data bits (even) or its inverse (odd); mismatch sets an internal parity flag; then -> STOP.
REQ-019 STOP: on the stop sample, p_data_out <= shift register, parity_error <= internal flag (0 when parity disabled), framing_error <= (sample = 0), data_valid = 1 for exactly that cycle; FSM -> IDLE in the same cycle.
REQ-020 data_valid SHALL assert for every completed frame, including errored ones.
REQ-021 p_data_out, parity_error and framing_error SHALL hold until the next data_valid.
REQ-022 A low line seen in IDLE immediately after STOP SHALL start a new frame with no dead cycles (back-to-back frames).
REQ-023 Changes to parity_en or parity_type mid-frame SHALL NOT affect the frame in progress.

Reset
REQ-024 While rst = 1 at a clock edge: FSM -> IDLE; counter, bit index, shift register and internal flag -> 0; synchronizer flops -> 1; p_data_out = 0, data_valid = 0, parity_error = 0, framing_error = 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no data_valid; reception restarts only on a new start edge after rst deasserts.

Verification
REQ-026 OVERSAMPLE=8, parity_en=0, frame 0/bits of 8'h0F LSB first/stop 1 -> exactly one data_valid, p_data_out=8'h0F, both errors 0.
REQ-027 parity_en=1, parity_type=0, data 8'hA5 with parity bit 0 -> p_data_out=8'hA5, parity_error=0; same frame with parity bit 1 -> parity_error=1, data_valid still pulses.
REQ-028 parity_type=1, data 8'h01 with parity bit 0 -> parity_error=0; stop bit driven 0 -> framing_error=1, p_data_out=8'h01.
REQ-029 Line low for 2 cycles then high -> no data_valid, FSM back in IDLE, outputs unchanged.
REQ-030 Frames 8'h3C and 8'hC3 back-to-back with one stop bit each -> two data_valid pulses, values 8'h3C then 8'hC3, no errors.
REQ-031 rst pulsed during DATA bit 4 of a frame -> all outputs 0, no data_valid; next clean frame 8'h55 -> p_data_out=8'h55.
